// File: rtl/mostra_jogada.sv
// mostra_jogada: flashes a captured 2-bit play code as a timed one-hot LED pulse.
// Ports:
//   clock, clear (sync, active-high), iniciar (start), codigo[1:0] (code)
//   leds[3:0] (one-hot), ocupado (busy), pronto (done pulse)
//   db_estado[1:0] (FSM state), present only when MOSTRA_JOGADA_DEBUG_EN is defined.
module mostra_jogada #(
    parameter int unsigned T_ON  = 4,
    parameter int unsigned T_OFF = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       iniciar,
    input  logic [1:0] codigo,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto
`ifdef MOSTRA_JOGADA_DEBUG_EN
    ,
    output logic [1:0] db_estado
`endif
);

    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        ACESO   = 2'b01,
        APAGADO = 2'b10,
        FIM     = 2'b11
    } estado_t;

    localparam logic [15:0] ON_LAST  = 16'(T_ON - 1);
    localparam logic [15:0] OFF_LAST = 16'(T_OFF - 1);
    localparam bit          NO_GAP   = (T_OFF == 0);

    estado_t     estado_q, estado_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cod_q, cod_d;
    logic [3:0]  leds_q, leds_d;
    logic        ocupado_q, ocupado_d;
    logic        pronto_q, pronto_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cod_d    = cod_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    cod_d    = codigo;
                    cnt_d    = 16'd0;
                    estado_d = ACESO;
                end
            end
            ACESO: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d    = 16'd0;
                    estado_d = NO_GAP ? FIM : APAGADO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            APAGADO: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d    = 16'd0;
                    estado_d = FIM;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FIM: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        leds_d    = (estado_d == ACESO) ? (4'b0001 << cod_d) : 4'b0000;
        ocupado_d = (estado_d != INICIAL);
        pronto_d  = (estado_d == FIM);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            estado_q  <= INICIAL;
            cnt_q     <= 16'd0;
            cod_q     <= 2'b00;
            leds_q    <= 4'b0000;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            cod_q     <= cod_d;
            leds_q    <= leds_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign leds    = leds_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

`ifdef MOSTRA_JOGADA_DEBUG_EN
    assign db_estado = estado_q;
`endif

endmodule

// File: tb/tb_mostra_jogada.sv
// tb_mostra_jogada: directed checks of mostra_jogada.
// Instance u0 uses T_ON=4/T_OFF=2, instance u1 uses T_ON=4/T_OFF=0.
module tb_mostra_jogada;

    logic       clock = 1'b0;
    logic       clear, iniciar;
    logic [1:0] codigo;
    logic [3:0] leds;
    logic       ocupado, pronto;

    logic       clear1, iniciar1;
    logic [1:0] codigo1;
    logic [3:0] leds1;
    logic       ocupado1, pronto1;

`ifdef MOSTRA_JOGADA_DEBUG_EN
    logic [1:0] db_estado, db_estado1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mostra_jogada #(.T_ON(4), .T_OFF(2)) u0 (
        .clock   (clock),
        .clear   (clear),
        .iniciar (iniciar),
        .codigo  (codigo),
        .leds    (leds),
        .ocupado (ocupado),
        .pronto  (pronto)
`ifdef MOSTRA_JOGADA_DEBUG_EN
        ,
        .db_estado (db_estado)
`endif
    );

    mostra_jogada #(.T_ON(4), .T_OFF(0)) u1 (
        .clock   (clock),
        .clear   (clear1),
        .iniciar (iniciar1),
        .codigo  (codigo1),
        .leds    (leds1),
        .ocupado (ocupado1),
        .pronto  (pronto1)
`ifdef MOSTRA_JOGADA_DEBUG_EN
        ,
        .db_estado (db_estado1)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs,
                       input logic [5:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Packs {leds, ocupado, pronto} of u0.
    function automatic logic [5:0] st0();
        return {leds, ocupado, pronto};
    endfunction

    function automatic logic [5:0] st1();
        return {leds1, ocupado1, pronto1};
    endfunction

    // Runs one flash on u0; if poke>0, pulses iniciar with codigo=01
    // so that it is sampled at edge 'poke' (mid-flash, must be ignored).
    task automatic run_flash(input string tag, input logic [1:0] code,
                             input logic [3:0] lit, input int poke);
        int pulses;
        logic [5:0] e;
        pulses  = 0;
        codigo  = code;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            if (c <= 4)      e = {lit, 1'b1, 1'b0};
            else if (c <= 6) e = {4'b0000, 1'b1, 1'b0};
            else if (c == 7) e = {4'b0000, 1'b1, 1'b1};
            else             e = 6'b000000;
            chk($sformatf("%s_c%0d", tag, c), st0(), e);
            if (pronto) pulses++;
            if (poke > 0 && c == poke) begin
                iniciar = 1'b1;
                codigo  = 2'b01;
            end else begin
                iniciar = 1'b0;
            end
        end
        chk($sformatf("%s_pulses", tag), 6'(pulses), 6'd1);
    endtask

    initial begin
        clear    = 1'b1;
        iniciar  = 1'b1;
        codigo   = 2'b10;
        clear1   = 1'b1;
        iniciar1 = 1'b0;
        codigo1  = 2'b00;

        // Reset with iniciar high: nothing starts.
        tick();
        chk("rst_e1", st0(), 6'b000000);
        tick();
        chk("rst_e2", st0(), 6'b000000);
`ifdef MOSTRA_JOGADA_DEBUG_EN
        chk("rst_db", {4'b0, db_estado}, 6'd0);
`endif
        clear   = 1'b0;
        iniciar = 1'b0;
        tick();
        chk("idle", st0(), 6'b000000);

        // Single flash and every code.
        run_flash("f10", 2'b10, 4'b0100, 0);
        run_flash("f00", 2'b00, 4'b0001, 0);
        run_flash("f01", 2'b01, 4'b0010, 0);
        run_flash("f11", 2'b11, 4'b1000, 0);

        // Busy ignore: second iniciar at cycle 3 while flashing 11.
        run_flash("busy", 2'b11, 4'b1000, 3);
        tick();
        chk("busy_idle", st0(), 6'b000000);

        // Mid-operation reset.
        codigo  = 2'b01;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("mid_c1", st0(), {4'b0010, 1'b1, 1'b0});
        tick();
        chk("mid_c2", st0(), {4'b0010, 1'b1, 1'b0});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("mid_rst", st0(), 6'b000000);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (pronto) pulses++;
            end
            chk("mid_nopronto", 6'(pulses), 6'd0);
        end
        run_flash("after", 2'b00, 4'b0001, 0);

        // T_OFF=0 instance with iniciar held high: period 6.
        clear1   = 1'b0;
        iniciar1 = 1'b1;
        codigo1  = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            logic [5:0] e;
            tick();
            case (c % 6)
                1, 2, 3, 4: e = {4'b1000, 1'b1, 1'b0};
                5:          e = {4'b0000, 1'b1, 1'b1};
                default:    e = 6'b000000;
            endcase
            chk($sformatf("nogap_c%0d", c), st1(), e);
        end
        iniciar1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mostra_jogada.md
Name: mostra_jogada

Overview:
- Reader/display end of the 2-bit play-code path: takes a stored 2-bit jogada code and presents it to the player as a timed one-hot LED flash.
- Started by the game control unit, once per sequence element during the "show sequence" phase. Signals completion with a one-cycle pulse.
- Decodes 2-bit codes to one-hot LEDs: 00->0001, 01->0010, 10->0100, 11->1000.

Parameters:
- T_ON, 4, clock cycles the LED stays lit (legal range 1..2^16-1).
- T_OFF, 2, clock cycles of dark gap after the flash (legal range 0..2^16-1; 0 means no gap).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset, synchronous, active-high.
- iniciar  input  1  start request; sampled only in state INICIAL.
- codigo  input  2  play code to display; captured on an accepted iniciar.
- leds  output  4  one-hot LED drive, registered.
- ocupado  output  1  high while a display is in progress (ACESO, APAGADO, FIM).
- pronto  output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset: clear is sampled at a rising clock edge. It forces state INICIAL, leds=0000, ocupado=0, pronto=0, counter=0 and the captured code to 00. Clear has priority over every other input.
- Reset mid-operation: a flash in progress is aborted at the next edge and no pronto pulse is produced.
- FSM states: INICIAL, ACESO, APAGADO, FIM.
- INICIAL:
  - leds=0, ocupado=0.
  - If iniciar=1 at edge k: codigo is captured, the counter loads 0, and the state becomes ACESO.
  - From cycle k+1, leds=onehot(captured code). Latency from accepted iniciar to lit LED is 1 cycle.
- ACESO:
  - leds=onehot(captured code); the counter increments each cycle.
  - After exactly T_ON cycles in ACESO, go to APAGADO (T_OFF>0) or FIM (T_OFF=0), with counter reset to 0.
- APAGADO:
  - leds=0000 for exactly T_OFF cycles, then go to FIM.
- FIM:
  - One cycle with pronto=1, leds=0, ocupado=1.
  - Unconditionally return to INICIAL.
  - pronto is high only in FIM.
- Start handling:
  - iniciar is ignored while ocupado=1.
  - Changes on codigo after capture have no effect on the flash in progress.
  - iniciar held high continuously: a new flash starts on the first cycle back in INICIAL, giving back-to-back flashes separated by one INICIAL cycle.
- Counter:
  - Width 16 bits, unsigned. It never wraps within legal parameter ranges.
  - The terminal comparison is against T_ON-1 / T_OFF-1.
- Total cycles from accepted iniciar edge to pronto-high cycle: T_ON+T_OFF+1.
- ocupado timing: ocupado=1 from the cycle after acceptance up to and including the FIM cycle.

Optional Feature:
- Macro: MOSTRA_JOGADA_DEBUG_EN.
- When defined: adds output port db_estado, 2 bits, registered. Encoding: INICIAL=00, ACESO=01, APAGADO=10, FIM=11. It is driven from the FSM state register; reset value 00.
- When undefined: the port does not exist, and functional behaviour is identical.

Test Plan (T_ON=4, T_OFF=2):
- Reset: clear=1 for 2 edges with iniciar=1 -> leds=0000, ocupado=0, pronto=0 throughout; no flash starts.
- Single flash: codigo=10 and iniciar pulsed at edge 0 -> leds=0100 for cycles 1-4, then 0000 for cycles 5-6, then pronto=1 only in cycle 7; ocupado=1 in cycles 1-7.
- All codes: 00/01/11 each started in turn -> leds=0001/0010/1000 respectively during ACESO; each completes with exactly one pronto pulse.
- Busy ignore: iniciar pulsed again at cycle 3 with codigo=01 during a flash of 11 -> leds stays 1000; exactly one pronto pulse; no second flash.
- Mid-op reset: clear=1 at cycle 2 of a flash -> leds=0000 and ocupado=0 the next cycle; no pronto pulse; a later iniciar starts normally.
- T_OFF=0 build with iniciar held high -> leds lit 4 cycles, then FIM (pronto=1), then one INICIAL cycle, then the next flash. Period is 6 cycles.
